mux_rr_scheduler: RTL and testbench

- Round-robin scheduler that shares one 4:1 single-bit data mux between four requesters.
- Generates the 2-bit mux select, a one-hot grant and a registered mux output with a valid flag.
- Sits in front of the 4:1 select datapath in the Tiny Tapeout user design. Requester req/data arrive on dedicated inputs; grant, select and data leave on dedicated outputs.
- Bounds each grant to HOLD_MAX cycles so that no requester starves the others.

---
 rtl/mux_rr_scheduler.sv | 138 +++++++++++++
 tb/tb_mux_rr_scheduler.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler for a shared 4:1 single-bit mux, with bounded grant tenure.
// Optional macro MUX_SCHED_STATS_EN enables the grant-start counter on switch_cnt.
module mux_rr_scheduler #(
  parameter int unsigned HOLD_MAX = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] req,
  input  logic [3:0] din,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       dout,
  output logic       dvalid,
  output logic       busy,
  output logic [7:0] switch_cnt
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic [3:0]         gnt_q, gnt_d;
  logic [1:0]         sel_q, sel_d;
  logic               dout_q, dout_d;
  logic               dvalid_q, dvalid_d;
  logic               grant_start;
  logic [1:0]         arb_ptr;
  logic [1:0]         winner;

  // First set request scanning upward from p, wrapping mod 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  // On release the pointer moves past the owner in the same edge, so arbitrate from there.
  assign arb_ptr = (state_q == StGrant) ? sel_q + 2'd1 : ptr_q;
  assign winner  = rr_pick(req, arb_ptr);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    grant_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ena && (req != 4'b0000)) begin
          state_d     = StGrant;
          gnt_d       = 4'b0001 << winner;
          sel_d       = winner;
          hold_d      = '0;
          grant_start = 1'b1;
        end
      end
      StGrant: begin
        if (ena && req[sel_q] && (hold_q < CNT_W'(HOLD_MAX - 1))) begin
          hold_d = hold_q + CNT_W'(1);
        end else begin
          ptr_d = sel_q + 2'd1;
          if (ena && (req != 4'b0000)) begin
            gnt_d       = 4'b0001 << winner;
            sel_d       = winner;
            hold_d      = '0;
            grant_start = 1'b1;
          end else begin
            state_d = StIdle;
            gnt_d   = 4'b0000;
            hold_d  = '0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // Datapath uses the pre-edge select, so a switching edge still samples the old leg.
  always_comb begin
    dout_d   = (state_q == StGrant) ? din[sel_q] : 1'b0;
    dvalid_d = (state_q == StGrant);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= 2'd0;
      hold_q   <= '0;
      gnt_q    <= 4'b0000;
      sel_q    <= 2'd0;
      dout_q   <= 1'b0;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      gnt_q    <= gnt_d;
      sel_q    <= sel_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign gnt    = gnt_q;
  assign sel    = sel_q;
  assign dout   = dout_q;
  assign dvalid = dvalid_q;
  assign busy   = (state_q == StGrant);

`ifdef MUX_SCHED_STATS_EN
  logic [7:0] switch_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      switch_cnt_q <= 8'h00;
    end else if (grant_start) begin
      switch_cnt_q <= switch_cnt_q + 8'd1;
    end
  end

  assign switch_cnt = switch_cnt_q;
`else
  logic unused_grant_start;
  assign unused_grant_start = grant_start;
  assign switch_cnt         = 8'h00;
`endif

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed self-checking bench for mux_rr_scheduler (HOLD_MAX=4).
module tb_mux_rr_scheduler;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       dout;
  logic       dvalid;
  logic       busy;
  logic [7:0] switch_cnt;

  int errors = 0;
  int checks = 0;

  mux_rr_scheduler #(
    .HOLD_MAX(4),
    .CNT_W   (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .req       (req),
    .din       (din),
    .gnt       (gnt),
    .sel       (sel),
    .dout      (dout),
    .dvalid    (dvalid),
    .busy      (busy),
    .switch_cnt(switch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] stat(input logic [7:0] n);
`ifdef MUX_SCHED_STATS_EN
    stat = n;
`else
    stat = 8'h00;
`endif
  endfunction

  initial begin
    rst_n = 1'b0;
    ena   = 1'b1;
    req   = 4'hF;
    din   = 4'hF;

    // Reset held with full load on the inputs.
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_sel", 32'(sel), 32'h0);
      check("rst_dout", 32'(dout), 32'h0);
      check("rst_dvalid", 32'(dvalid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_swcnt", 32'(switch_cnt), 32'h0);
    end

    // Single requester 2, re-granted every 4 cycles with no gap.
    rst_n = 1'b1;
    req   = 4'b0100;
    din   = 4'b0100;
    step();
    check("single_gnt", 32'(gnt), 32'h4);
    check("single_sel", 32'(sel), 32'h2);
    check("single_busy", 32'(busy), 32'h1);
    check("single_dvalid0", 32'(dvalid), 32'h0);
    check("single_swcnt1", 32'(switch_cnt), 32'(stat(8'd1)));
    step();
    check("single_dout", 32'(dout), 32'h1);
    check("single_dvalid", 32'(dvalid), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("single_hold_gnt", 32'(gnt), 32'h4);
    end
    check("single_regrant_swcnt", 32'(switch_cnt), 32'(stat(8'd2)));
    check("single_regrant_busy", 32'(busy), 32'h1);

    // Full load rotation from reset: 0,0,0,0,1,1,1,1,2,...
    do_reset();
    req = 4'hF;
    for (int i = 0; i < 16; i++) begin
      step();
      check("rot_sel", 32'(sel), 32'(i / 4));
      check("rot_gnt", 32'(gnt), 32'(4'b0001 << (i / 4)));
      check("rot_busy", 32'(busy), 32'h1);
    end
    step();
    check("rot_wrap_sel", 32'(sel), 32'h0);

    // Early release of requester 1 while requester 3 waits.
    do_reset();
    req = 4'b0010;
    din = 4'b0010;
    step();
    check("early_gnt1", 32'(gnt), 32'h2);
    step();
    check("early_dout_leg1", 32'(dout), 32'h1);
    req = 4'b1000;
    din = 4'b1000;
    step();
    check("early_gnt3", 32'(gnt), 32'h8);
    check("early_sel3", 32'(sel), 32'h3);
    check("early_dvalid", 32'(dvalid), 32'h1);
    check("early_no_mix", 32'(dout), 32'h0);
    step();
    check("early_dout_leg3", 32'(dout), 32'h1);
    // Requester 3 drops; pointer sat at 2, so requesters 2 then 0 compete from index 0.
    req = 4'b0101;
    step();
    check("early_next_ptr", 32'(sel), 32'h0);

    // ena abort during grant to requester 0.
    do_reset();
    req = 4'b0001;
    din = 4'b0000;
    step();
    check("abort_gnt0", 32'(gnt), 32'h1);
    ena = 1'b0;
    req = 4'hF;
    step();
    check("abort_gnt", 32'(gnt), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_dvalid_lag", 32'(dvalid), 32'h1);
    step();
    check("abort_dvalid", 32'(dvalid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_no_grant", 32'(gnt), 32'h0);
      check("abort_sel_hold", 32'(sel), 32'h0);
    end
    ena = 1'b1;
    step();
    check("abort_resume_sel", 32'(sel), 32'h1);

    // 300 grant starts under full load: one start every 4 cycles.
    do_reset();
    req = 4'hF;
    step();
    check("stats_first", 32'(switch_cnt), 32'(stat(8'd1)));
    for (int i = 0; i < 299 * 4; i++) step();
    check("stats_wrap", 32'(switch_cnt), 32'(stat(8'd44)));
    check("stats_busy", 32'(busy), 32'h1);

    // Reset mid-operation.
    rst_n = 1'b0;
    step();
    check("midrst_gnt", 32'(gnt), 32'h0);
    check("midrst_dvalid", 32'(dvalid), 32'h0);
    check("midrst_swcnt", 32'(switch_cnt), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
